// File: rtl/ysyx_23060203_ifu_pkg.sv
// ============================================================================
// Module   : ysyx_23060203_ifu_pkg
// Brief    : Shared definitions for the NPC instruction fetch unit: FSM state
//            encodings, default reset PC and AXI response codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_23060203_ifu_pkg;

  // Fetch FSM states, 3-bit encoding
  typedef enum logic [2:0] {
    IFU_IDLE    = 3'd0,
    IFU_ADDR    = 3'd1,
    IFU_DATA    = 3'd2,
    IFU_OUT     = 3'd3,
    IFU_WAIT_PC = 3'd4
  } ifu_state_e;

  // Architectural PC after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // AXI read response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Anything other than OKAY is treated as an access fault by the core
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060203_pc_reg.sv
// ============================================================================
// Module   : ysyx_23060203_pc_reg
// Brief    : 32-bit PC register with load enable, async active-low reset to
//            RESET_PC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060203_pc_reg
  import ysyx_23060203_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_pc;

  // Hold the PC unless write-back supplies a new one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_d;
    end
  end

  assign o_q = r_pc;

endmodule

`default_nettype wire

// File: rtl/ysyx_23060203_ifu.sv
// ============================================================================
// Module   : ysyx_23060203_ifu
// Brief    : Multi-cycle instruction fetch unit. Owns the PC, issues one
//            AXI4-Lite read per instruction, hands {inst, pc, err} to the IDU
//            over valid/ready and then waits for write-back to supply dnpc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060203_ifu
  import ysyx_23060203_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  // AXI4-Lite read channels toward memory
  output logic [31:0] ifu_araddr,
  output logic        ifu_arvalid,
  input  logic        ifu_arready,
  input  logic [31:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp,
  input  logic        ifu_rvalid,
  output logic        ifu_rready,
  // Toward IDU
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        out_err,
  output logic        out_valid,
  input  logic        out_ready,
  // From write-back
  input  logic [31:0] dnpc,
  input  logic        dnpc_valid
);

  ifu_state_e  r_state;
  ifu_state_e  w_state_next;
  logic        r_arvalid;
  logic        w_arvalid_next;
  logic        r_rready;
  logic        w_rready_next;
  logic        r_out_valid;
  logic        w_out_valid_next;
  logic        w_capture;
  logic        w_pc_load;
  logic [31:0] r_inst;
  logic        r_err;
  logic [31:0] w_pc;

  // Next state plus next values of the registered handshake outputs
  always_comb begin
    w_state_next     = r_state;
    w_arvalid_next   = r_arvalid;
    w_rready_next    = r_rready;
    w_out_valid_next = r_out_valid;
    w_capture        = 1'b0;
    w_pc_load        = 1'b0;
    case (r_state)
      IFU_IDLE: begin
        w_state_next   = IFU_ADDR;
        w_arvalid_next = 1'b1;
      end
      IFU_ADDR: begin
        if (r_arvalid && ifu_arready) begin
          w_state_next   = IFU_DATA;
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
        end
      end
      IFU_DATA: begin
        if (r_rready && ifu_rvalid) begin
          w_state_next     = IFU_OUT;
          w_rready_next    = 1'b0;
          w_out_valid_next = 1'b1;
          w_capture        = 1'b1;
        end
      end
      IFU_OUT: begin
        if (r_out_valid && out_ready) begin
          w_state_next     = IFU_WAIT_PC;
          w_out_valid_next = 1'b0;
        end
      end
      IFU_WAIT_PC: begin
        // dnpc_valid is only honoured here; elsewhere the PC is left alone
        if (dnpc_valid) begin
          w_pc_load      = 1'b1;
          w_state_next   = IFU_ADDR;
          w_arvalid_next = 1'b1;
        end
      end
      default: begin
        w_state_next     = IFU_IDLE;
        w_arvalid_next   = 1'b0;
        w_rready_next    = 1'b0;
        w_out_valid_next = 1'b0;
      end
    endcase
  end

  // State and handshake output registers; reset drops all valids at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IFU_IDLE;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_arvalid   <= w_arvalid_next;
      r_rready    <= w_rready_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  // Capture the fetched word; a faulting fetch delivers a zero instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst <= 32'h0000_0000;
      r_err  <= 1'b0;
    end else if (w_capture) begin
      r_inst <= resp_is_err(ifu_rresp) ? 32'h0000_0000 : ifu_rdata;
      r_err  <= resp_is_err(ifu_rresp);
    end
  end

  ysyx_23060203_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_pc_load),
    .i_d    (dnpc),
    .o_q    (w_pc)
  );

  assign ifu_araddr  = w_pc;
  assign ifu_arvalid = r_arvalid;
  assign ifu_rready  = r_rready;
  assign inst        = r_inst;
  assign pc          = w_pc;
  assign out_err     = r_err;
  assign out_valid   = r_out_valid;

`ifndef SYNTHESIS
  // Flag a write-back redirect that arrives while no fetch is waiting for it
  always_ff @(posedge clk) begin
    if (rst_n && dnpc_valid) begin
      assert (r_state == IFU_WAIT_PC)
        else $warning("ifu: dnpc_valid outside WAIT_PC ignored (state=%0d)", r_state);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060203_ifu.sv
// ============================================================================
// Module   : tb_ysyx_23060203_ifu
// Brief    : Self-checking bench for the fetch unit. Expected fetch results are
//            queued when a read is issued and compared when the IDU side
//            presents the instruction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060203_ifu;

  localparam logic [31:0] C_RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dnpc;
  logic        dnpc_valid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  ysyx_23060203_ifu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ifu_araddr  (ifu_araddr),
    .ifu_arvalid (ifu_arvalid),
    .ifu_arready (ifu_arready),
    .ifu_rdata   (ifu_rdata),
    .ifu_rresp   (ifu_rresp),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rready  (ifu_rready),
    .inst        (inst),
    .pc          (pc),
    .out_err     (out_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dnpc        (dnpc),
    .dnpc_valid  (dnpc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_arvalid();
    int n = 0;
    while (ifu_arvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arvalid_seen", {31'b0, ifu_arvalid}, 32'd1);
  endtask

  // Pulse dnpc while waiting for the next PC; the read must start next cycle
  task automatic redirect(input logic [31:0] npc);
    dnpc       = npc;
    dnpc_valid = 1'b1;
    @(negedge clk);
    dnpc_valid = 1'b0;
    dnpc       = $urandom;
    chk("redir_arvalid", {31'b0, ifu_arvalid}, 32'd1);
    chk("redir_araddr", ifu_araddr, npc);
  endtask

  // One complete fetch with configurable memory and IDU stalls
  task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] data,
                       input logic [1:0] resp, input int ar_stall,
                       input int r_stall, input int out_stall);
    exp_t e;
    logic bad;
    bad = (resp != 2'b00);
    sb_q.push_back('{pc: exp_pc, inst: (bad ? 32'h0 : data), err: bad});
    wait_arvalid();
    chk("araddr", ifu_araddr, exp_pc);
    for (int i = 0; i < ar_stall; i++) begin
      ifu_arready = 1'b0;
      @(negedge clk);
      chk("ar_hold_valid", {31'b0, ifu_arvalid}, 32'd1);
      chk("ar_hold_addr", ifu_araddr, exp_pc);
    end
    ifu_arready = 1'b1;
    @(negedge clk);
    ifu_arready = 1'b0;
    chk("data_rready", {31'b0, ifu_rready}, 32'd1);
    chk("data_arvalid", {31'b0, ifu_arvalid}, 32'd0);
    for (int i = 0; i < r_stall; i++) begin
      @(negedge clk);
      chk("r_hold_rready", {31'b0, ifu_rready}, 32'd1);
    end
    ifu_rvalid = 1'b1;
    ifu_rdata  = data;
    ifu_rresp  = resp;
    @(negedge clk);
    ifu_rvalid = 1'b0;
    ifu_rdata  = $urandom;
    ifu_rresp  = 2'b00;
    chk("out_valid", {31'b0, out_valid}, 32'd1);
    chk("out_rready", {31'b0, ifu_rready}, 32'd0);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
    chk("inst", inst, e.inst);
    chk("pc", pc, e.pc);
    chk("out_err", {31'b0, out_err}, {31'b0, e.err});
    for (int i = 0; i < out_stall; i++) begin
      out_ready = 1'b0;
      if (i == 1) begin
        dnpc       = 32'h1234_5678;
        dnpc_valid = 1'b1;
      end
      @(negedge clk);
      dnpc_valid = 1'b0;
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_inst", inst, e.inst);
      chk("bp_pc", pc, e.pc);
      chk("bp_no_ar", {31'b0, ifu_arvalid}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("accepted", {31'b0, out_valid}, 32'd0);
    chk("wait_no_ar", {31'b0, ifu_arvalid}, 32'd0);
  endtask

  initial begin
    exp_t e;
    rst_n       = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = 32'h0;
    ifu_rresp   = 2'b00;
    ifu_rvalid  = 1'b0;
    out_ready   = 1'b0;
    dnpc        = 32'h0;
    dnpc_valid  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_arvalid", {31'b0, ifu_arvalid}, 32'd0);
    chk("rst_rready", {31'b0, ifu_rready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", pc, C_RESET_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_err", {31'b0, out_err}, 32'd0);

    // Minimum-latency first fetch with every ready/valid tied high
    ifu_arready = 1'b1;
    ifu_rvalid  = 1'b1;
    ifu_rdata   = 32'h0000_0093;
    out_ready   = 1'b1;
    rst_n       = 1'b1;
    sb_q.push_back('{pc: C_RESET_PC, inst: 32'h0000_0093, err: 1'b0});
    @(negedge clk);
    chk("lat1_arvalid", {31'b0, ifu_arvalid}, 32'd1);
    chk("lat1_araddr", ifu_araddr, C_RESET_PC);
    chk("lat1_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat2_rready", {31'b0, ifu_rready}, 32'd1);
    chk("lat2_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat3_out_valid", {31'b0, out_valid}, 32'd1);
    e = sb_q.pop_front();
    chk("lat3_inst", inst, e.inst);
    chk("lat3_pc", pc, e.pc);
    chk("lat3_err", {31'b0, out_err}, {31'b0, e.err});
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("lat4_out_valid", {31'b0, out_valid}, 32'd0);
    chk("lat4_arvalid", {31'b0, ifu_arvalid}, 32'd0);

    // Redirect, then memory stalls on both channels
    redirect(32'h8000_0100);
    fetch(32'h8000_0100, 32'h0050_0113, 2'b00, 5, 4, 0);

    // IDU backpressure with an ignored redirect pulse in OUT
    redirect(32'h8000_0104);
    fetch(32'h8000_0104, 32'h00a0_0193, 2'b00, 0, 0, 10);

    // Slave error: zero instruction, err flagged, handshake completes
    redirect(32'h8000_0108);
    fetch(32'h8000_0108, 32'hDEAD_BEEF, 2'b10, 0, 1, 2);
    // EXOKAY is not OKAY, so it faults as well
    redirect(32'h8000_010C);
    fetch(32'h8000_010C, 32'h1111_2222, 2'b01, 1, 0, 0);
    // An OKAY fetch afterwards clears the error flag
    redirect(32'h8000_0110);
    fetch(32'h8000_0110, 32'h0000_8067, 2'b00, 0, 0, 1);

    // Reset while the data phase is outstanding
    redirect(32'h8000_0200);
    ifu_arready = 1'b1;
    @(negedge clk);
    ifu_arready = 1'b0;
    chk("mid_rready", {31'b0, ifu_rready}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_rready", {31'b0, ifu_rready}, 32'd0);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_arvalid", {31'b0, ifu_arvalid}, 32'd0);
    chk("mid_rst_pc", pc, C_RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    chk("restart_idle", {31'b0, ifu_arvalid}, 32'd0);
    fetch(C_RESET_PC, 32'h0000_0013, 2'b00, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a handshake never completes
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
